mem_port_arbiter: RTL and testbench

//  Shares the single-port program/data memory between two requesters: the CPU

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port around mem_port_arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic              dbg_err;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              owner;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_err, dbg_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output owner, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_err, dbg_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and a
// debug/DMA port: one transaction in flight, wait states, watchdog abort.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_req_q, mem_req_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              dbg_err_q, dbg_err_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic              win;
    logic              timed_out;
    logic [DATA_W-1:0] result;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_req_d    = mem_req_q;
        cnt_d        = cnt_q;
        cpu_ack_d    = 1'b0;
        cpu_err_d    = cpu_err_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_ack_d    = 1'b0;
        dbg_err_d    = dbg_err_q;
        dbg_rdata_d  = dbg_rdata_q;
        win          = 1'b0;
        timed_out    = 1'b0;
        result       = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    // On a tie the requester served last time yields.
                    win       = (bus.cpu_req && bus.dbg_req) ? ~last_grant_q : bus.dbg_req;
                    owner_d   = win;
                    we_d      = win ? bus.dbg_we    : bus.cpu_we;
                    addr_d    = win ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_d   = win ? bus.dbg_wdata : bus.cpu_wdata;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Ready wins over the watchdog when both land on the same cycle.
                if (bus.mem_ready || cnt_q == 8'(TIMEOUT - 1)) begin
                    timed_out = ~bus.mem_ready;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (owner_q) begin
                        result      = we_q ? dbg_rdata_q : bus.mem_rdata;
                        dbg_ack_d   = 1'b1;
                        dbg_err_d   = timed_out;
                        dbg_rdata_d = timed_out ? '0 : result;
                    end else begin
                        result      = we_q ? cpu_rdata_q : bus.mem_rdata;
                        cpu_ack_d   = 1'b1;
                        cpu_err_d   = timed_out;
                        cpu_rdata_d = timed_out ? '0 : result;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_req_q    <= 1'b0;
            cnt_q        <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_req_q    <= mem_req_d;
            cnt_q        <= cnt_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_err_q    <= dbg_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_err   = dbg_err_q;
    assign bus.dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_DONE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester 0 = CPU, 1 = debug.
    bit          r_req   [2];
    bit          r_we    [2];
    logic [15:0] r_addr  [2];
    logic [15:0] r_wdata [2];
    int          r_gap   [2];
    bit          r_auto  [2];
    int          gap_max    = 0;
    int          cfg_wait   = -1;
    bit          idle_ready = 1'b0;

    int          ph      = PH_IDLE;
    bit          m_owner = 1'b0;
    bit          last_g  = 1'b1;
    bit          m_err   = 1'b0;
    int          nbusy   = 0;
    int          wait_t  = 0;
    logic [15:0] exp_rdata [2];
    bit          drv_ready;
    logic [15:0] drv_rdata;
    int          acks [2];
    int          grants [$];
    logic [15:0] mem_m [logic [15:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic int pick_wait();
        int r;
        if (cfg_wait >= 0) return cfg_wait;
        r = $urandom_range(0, 15);
        if (r == 0) return TIMEOUT - 1;
        if (r == 1) return 99;
        return r % 5;
    endfunction

    task automatic new_txn(input int i);
        r_we[i]    = ($urandom_range(0, 2) == 0);
        r_addr[i]  = 16'h0100 + 16'($urandom_range(0, 15));
        r_wdata[i] = 16'($urandom);
    endtask

    task automatic drive();
        bus.cpu_req   = r_req[0];
        bus.cpu_we    = r_we[0];
        bus.cpu_addr  = r_addr[0];
        bus.cpu_wdata = r_wdata[0];
        bus.dbg_req   = r_req[1];
        bus.dbg_we    = r_we[1];
        bus.dbg_addr  = r_addr[1];
        bus.dbg_wdata = r_wdata[1];
        bus.mem_ready = drv_ready;
        bus.mem_rdata = drv_rdata;
    endtask

    task automatic issue(input int i, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        r_we[i]    = we;
        r_addr[i]  = addr;
        r_wdata[i] = wdata;
        r_req[i]   = 1'b1;
        drive();
    endtask

    // One clock: advance the model with the inputs just sampled, compare, drive next inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            ph           = PH_IDLE;
            last_g       = 1'b1;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
        end else begin
            case (ph)
                PH_IDLE: begin
                    if (r_req[0] || r_req[1]) begin
                        m_owner = (r_req[0] && r_req[1]) ? !last_g : r_req[1];
                        grants.push_back(int'(m_owner));
                        nbusy  = 1;
                        wait_t = pick_wait();
                        ph     = PH_BUSY;
                    end
                end
                PH_BUSY: begin
                    if (drv_ready) begin
                        m_err = 1'b0;
                        if (!r_we[m_owner]) exp_rdata[m_owner] = drv_rdata;
                        else mem_m[r_addr[m_owner]] = r_wdata[m_owner];
                        ph = PH_DONE;
                    end else if (nbusy == TIMEOUT) begin
                        m_err              = 1'b1;
                        exp_rdata[m_owner] = '0;
                        ph                 = PH_DONE;
                    end else begin
                        nbusy++;
                    end
                end
                PH_DONE: begin
                    last_g = m_owner;
                    ph     = PH_IDLE;
                end
                default: ph = PH_IDLE;
            endcase
        end

        chk("busy", bus.busy, ph != PH_IDLE);
        chk("mem_req", bus.mem_req, ph == PH_BUSY);
        chk("cpu_ack", bus.cpu_ack, ph == PH_DONE && !m_owner);
        chk("dbg_ack", bus.dbg_ack, ph == PH_DONE && m_owner);
        chk("cpu_rdata", bus.cpu_rdata, exp_rdata[0]);
        chk("dbg_rdata", bus.dbg_rdata, exp_rdata[1]);
        if (ph != PH_IDLE) chk("owner", bus.owner, m_owner);
        if (ph == PH_BUSY) begin
            chk("mem_we", bus.mem_we, r_we[m_owner]);
            chk("mem_addr", bus.mem_addr, r_addr[m_owner]);
            chk("mem_wdata", bus.mem_wdata, r_wdata[m_owner]);
        end
        if (ph == PH_DONE) chk("ack_err", m_owner ? bus.dbg_err : bus.cpu_err, m_err);
        if (rst) begin
            chk("rst_cpu_err", bus.cpu_err, 1'b0);
            chk("rst_dbg_err", bus.dbg_err, 1'b0);
            chk("rst_owner", bus.owner, 1'b0);
            chk("rst_mem_addr", bus.mem_addr, 16'h0);
            chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
            chk("rst_mem_we", bus.mem_we, 1'b0);
        end
        if (bus.cpu_ack === 1'b1) acks[0]++;
        if (bus.dbg_ack === 1'b1) acks[1]++;

        for (int i = 0; i < 2; i++) begin
            if (ph == PH_DONE && m_owner == i) begin
                if (!r_auto[i]) begin
                    r_req[i] = 1'b0;
                end else begin
                    r_gap[i] = $urandom_range(0, gap_max);
                    if (r_gap[i] == 0) new_txn(i);
                    else r_req[i] = 1'b0;
                end
            end else if (r_auto[i] && !r_req[i]) begin
                if (r_gap[i] > 0) r_gap[i]--;
                if (r_gap[i] == 0) begin
                    new_txn(i);
                    r_req[i] = 1'b1;
                end
            end
        end

        if (ph == PH_BUSY) begin
            drv_ready = (nbusy == wait_t + 1);
            drv_rdata = drv_ready ? memval(r_addr[m_owner]) : 16'($urandom);
        end else begin
            drv_ready = idle_ready ? 1'b1 : ($urandom_range(0, 3) == 0);
            drv_rdata = 16'($urandom);
        end
        drive();
    endtask

    task automatic wait_ack(input int i, input int budget, output int lat);
        int a0;
        a0  = acks[i];
        lat = 0;
        while (acks[i] == a0 && lat < budget) begin
            step();
            lat++;
        end
        chk("ack_within_budget", acks[i] != a0, 1'b1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        r_auto[0] = 1'b0;
        r_auto[1] = 1'b0;
        while ((ph != PH_IDLE || r_req[0] || r_req[1]) && g < 400) begin
            step();
            g++;
        end
        chk("drain_done", g < 400, 1'b1);
    endtask

    initial begin
        int lat;
        int a_base;
        int g;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
            r_gap[i] = 0; r_auto[i] = 1'b0; exp_rdata[i] = '0; acks[i] = 0;
        end
        drv_ready = 1'b0;
        drv_rdata = '0;
        drive();
        step();
        step();
        rst = 1'b0;

        // Plain CPU read with zero wait states.
        mem_m[16'h0010] = 16'hBEEF;
        cfg_wait = 0;
        issue(0, 1'b0, 16'h0010, 16'h0);
        wait_ack(0, 10, lat);
        chk("t1_latency", lat, 2);
        chk("t1_rdata", bus.cpu_rdata, 16'hBEEF);
        chk("t1_err", bus.cpu_err, 1'b0);
        step();
        step();
        chk("t1_no_dbg_ack", acks[1], 0);

        // Both requesting from reset release: strict alternation starting with the CPU.
        rst = 1'b1;
        r_auto[0] = 1'b1;
        r_auto[1] = 1'b1;
        gap_max   = 0;
        cfg_wait  = -1;
        new_txn(0); new_txn(1);
        r_req[0] = 1'b1;
        r_req[1] = 1'b1;
        drive();
        step();
        rst = 1'b0;
        grants.delete();
        a_base = acks[0] + acks[1];
        g = 0;
        while (acks[0] + acks[1] < a_base + 8 && g < 400) begin
            step();
            g++;
        end
        chk("t2_eight_acks", acks[0] + acks[1] >= a_base + 8, 1'b1);
        drain();
        for (int k = 0; k < 8; k++)
            chk("t2_alternate", (k < grants.size()) ? grants[k] : -1, k % 2);

        // Debug write with three wait states.
        step();
        cfg_wait = 3;
        a_base = acks[1];
        issue(1, 1'b1, 16'h00FF, 16'h1234);
        wait_ack(1, 20, lat);
        chk("t3_latency", lat, 5);
        step();
        step();
        chk("t3_single_ack", acks[1] - a_base, 1);

        // CPU read that never sees ready, then a normal read.
        cfg_wait = 99;
        issue(0, 1'b0, 16'h0020, 16'h0);
        wait_ack(0, 40, lat);
        chk("t4_timeout_latency", lat, TIMEOUT + 1);
        chk("t4_err", bus.cpu_err, 1'b1);
        chk("t4_rdata_zero", bus.cpu_rdata, 16'h0);
        step();
        cfg_wait = 0;
        issue(0, 1'b0, 16'h0021, 16'h0);
        wait_ack(0, 10, lat);
        chk("t4_recover_err", bus.cpu_err, 1'b0);
        chk("t4_recover_rdata", bus.cpu_rdata, memval(16'h0021));
        step();

        // Reset in the middle of a transaction.
        cfg_wait = 99;
        issue(0, 1'b0, 16'h0030, 16'h0);
        step();
        step();
        step();
        rst = 1'b1;
        r_req[0] = 1'b0;
        drive();
        a_base = acks[0];
        step();
        chk("t5_mem_req_low", bus.mem_req, 1'b0);
        chk("t5_busy_low", bus.busy, 1'b0);
        rst = 1'b0;
        step();
        chk("t5_no_ack", acks[0] - a_base, 0);
        cfg_wait = 0;
        issue(0, 1'b0, 16'h0031, 16'h0);
        wait_ack(0, 10, lat);
        chk("t5_latency", lat, 2);
        step();
        chk("t5_back_idle", bus.busy, 1'b0);

        // Ready pulses while idle are ignored; ready on the last allowed cycle succeeds.
        idle_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t6_idle_stays", bus.busy, 1'b0);
        idle_ready = 1'b0;
        cfg_wait = TIMEOUT - 1;
        mem_m[16'h0040] = 16'hCAFE;
        issue(1, 1'b0, 16'h0040, 16'h0);
        wait_ack(1, 40, lat);
        chk("t6_latency", lat, TIMEOUT + 1);
        chk("t6_err", bus.dbg_err, 1'b0);
        chk("t6_rdata", bus.dbg_rdata, 16'hCAFE);
        step();

        // Randomized traffic with gaps, wait states and occasional timeouts.
        cfg_wait  = -1;
        gap_max   = 3;
        r_auto[0] = 1'b1;
        r_auto[1] = 1'b1;
        a_base = acks[0] + acks[1];
        for (int k = 0; k < 3000; k++) step();
        drain();
        chk("rand_progress", (acks[0] + acks[1] - a_base) > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
